// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decodes funct3 for the comparator, resolves
// taken/not-taken and sequences flush + PC redirect on a misprediction.
module branch_resolve_unit #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    output logic             BrUn,
    input  logic             BrEq,
    input  logic             BrLt,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush,
    output logic             ex_stall,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_t;

    state_t            state_reg, state_next;
    logic [FC_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic              redir_valid_reg, redir_valid_next;
    logic [XLEN-1:0]   redir_pc_reg, redir_pc_next;
    logic [CNT_W-1:0]  br_count_reg, br_count_next;
    logic [CNT_W-1:0]  mispred_count_reg, mispred_count_next;

    logic              legal, taken, accept, mispredict, handshake;
    logic              cond_taken;
    logic [XLEN-1:0]   eff_target, correct_pc;

    assign BrUn = ex_funct3[1];

    always_comb begin
        cond_taken = 1'b0;
        case (ex_funct3)
            3'b000:  cond_taken = BrEq;
            3'b001:  cond_taken = !BrEq;
            3'b100:  cond_taken = BrLt;
            3'b101:  cond_taken = !BrLt;
            3'b110:  cond_taken = BrLt;
            3'b111:  cond_taken = !BrLt;
            default: cond_taken = 1'b0;
        endcase
    end

    // Multiple type flags set: jalr wins over jal, jal over branch.
    always_comb begin
        legal      = 1'b0;
        taken      = 1'b0;
        eff_target = ex_target;
        if (ex_is_jalr) begin
            legal      = 1'b1;
            taken      = 1'b1;
            eff_target = {ex_target[XLEN-1:1], 1'b0};
        end else if (ex_is_jal) begin
            legal = 1'b1;
            taken = 1'b1;
        end else if (ex_is_branch) begin
            legal = (ex_funct3[2:1] != 2'b01);
            taken = cond_taken;
        end
    end

    assign correct_pc = taken ? eff_target : (ex_pc + XLEN'(4));
    assign ex_stall   = (state_reg != IDLE);
    assign flush      = (state_reg == FLUSH);
    assign accept     = ex_valid && !ex_stall && legal;
    assign mispredict = accept && (taken != ex_pred_taken);
    assign handshake  = redir_valid_reg && redir_ready;

    always_comb begin
        state_next       = state_reg;
        flush_cnt_next   = flush_cnt_reg;
        redir_valid_next = redir_valid_reg;
        redir_pc_next    = redir_pc_reg;
        if (handshake) begin
            redir_valid_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                if (mispredict) begin
                    state_next       = FLUSH;
                    flush_cnt_next   = FC_LOAD;
                    redir_valid_next = 1'b1;
                    redir_pc_next    = correct_pc;
                end
            end
            FLUSH: begin
                if (flush_cnt_reg == '0) begin
                    state_next = (redir_valid_reg && !handshake) ? WAIT : IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg - FC_W'(1);
                end
            end
            WAIT: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        br_count_next      = br_count_reg;
        mispred_count_next = mispred_count_reg;
        if (accept && (br_count_reg != '1)) begin
            br_count_next = br_count_reg + CNT_W'(1);
        end
        if (mispredict && (mispred_count_reg != '1)) begin
            mispred_count_next = mispred_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            flush_cnt_reg     <= '0;
            redir_valid_reg   <= 1'b0;
            redir_pc_reg      <= '0;
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else begin
            state_reg         <= state_next;
            flush_cnt_reg     <= flush_cnt_next;
            redir_valid_reg   <= redir_valid_next;
            redir_pc_reg      <= redir_pc_next;
            br_count_reg      <= br_count_next;
            mispred_count_reg <= mispred_count_next;
        end
    end

    assign redir_valid   = redir_valid_reg;
    assign redir_pc      = redir_pc_reg;
    assign br_count      = br_count_reg;
    assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: inputs change and
// outputs are sampled on the falling clock edge.
module tb_branch_resolve_unit;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_pc, ex_target;
    logic             ex_pred_taken;
    logic             BrUn, BrEq, BrLt;
    logic             redir_valid, redir_ready;
    logic [XLEN-1:0]  redir_pc;
    logic             flush, ex_stall;
    logic [CNT_W-1:0] br_count, mispred_count;

    int errors = 0;
    int checks = 0;

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .BrUn(BrUn), .BrEq(BrEq), .BrLt(BrLt),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .flush(flush), .ex_stall(ex_stall),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_branch(input logic [2:0] f3, input logic pred,
                                input logic eq, input logic lt,
                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
        ex_funct3 = f3; ex_pred_taken = pred; BrEq = eq; BrLt = lt;
        ex_pc = pc; ex_target = tgt;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redir_ready = 1'b0;
        drive_idle(); ex_funct3 = 3'b000; ex_pred_taken = 1'b0;
        BrEq = 1'b0; BrLt = 1'b0; ex_pc = '0; ex_target = '0;
        #3;
        checks++;
        if ({redir_valid, flush, ex_stall} !== 3'b000 || br_count !== '0 || mispred_count !== '0 || redir_pc !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b f=%0b s=%0b br=%0d mp=%0d pc=%0h required all zero",
                     redir_valid, flush, ex_stall, br_count, mispred_count, redir_pc);
        end
        @(negedge clk); rst_n = 1'b1;
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_bltu_mispredict();
        @(negedge clk);
        drive_branch(3'b110, 1'b0, 1'b0, 1'b1, 64'h1000, 64'h0F00);
        #1;
        checks++;
        if (BrUn !== 1'b1) begin errors++; $display("FAIL bltu_brun got=%0b required=1", BrUn); end
        @(negedge clk); drive_idle();
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h0F00 || flush !== 1'b1) begin
            errors++; $display("FAIL bltu_redirect got v=%0b pc=%0h f=%0b required v=1 pc=f00 f=1", redir_valid, redir_pc, flush);
        end
        checks++;
        if (br_count !== 32'd1 || mispred_count !== 32'd1) begin
            errors++; $display("FAIL bltu_counts got br=%0d mp=%0d required br=1 mp=1", br_count, mispred_count);
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b1) begin errors++; $display("FAIL bltu_flush2 got=%0b required=1", flush); end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || ex_stall !== 1'b1 || redir_valid !== 1'b1) begin
            errors++; $display("FAIL bltu_wait got f=%0b s=%0b v=%0b required f=0 s=1 v=1", flush, ex_stall, redir_valid);
        end
        redir_ready = 1'b1;
        @(negedge clk); redir_ready = 1'b0;
        checks++;
        if (redir_valid !== 1'b0 || ex_stall !== 1'b0) begin
            errors++; $display("FAIL bltu_done got v=%0b s=%0b required v=0 s=0", redir_valid, ex_stall);
        end
        $display("txn bltu: mispredict redirect to 0f00");
    endtask

    task automatic test_bge_correct();
        @(negedge clk);
        drive_branch(3'b101, 1'b0, 1'b0, 1'b1, 64'h2000, 64'h2100);
        #1;
        checks++;
        if (BrUn !== 1'b0) begin errors++; $display("FAIL bge_brun got=%0b required=0", BrUn); end
        @(negedge clk); drive_idle();
        checks++;
        if (redir_valid !== 1'b0 || flush !== 1'b0 || br_count !== 32'd2 || mispred_count !== 32'd1) begin
            errors++; $display("FAIL bge_correct got v=%0b f=%0b br=%0d mp=%0d required v=0 f=0 br=2 mp=1",
                               redir_valid, flush, br_count, mispred_count);
        end
        $display("txn bge: correctly predicted not-taken");
    endtask

    task automatic test_bne_wrap_stall();
        @(negedge clk);
        drive_branch(3'b001, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4000);
        // EX keeps presenting a mispredicting branch while stalled; it must be ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (redir_valid !== 1'b1 || redir_pc !== 64'h0 || ex_stall !== 1'b1) begin
                errors++; $display("FAIL bne_hold%0d got v=%0b pc=%0h s=%0b required v=1 pc=0 s=1",
                                   i, redir_valid, redir_pc, ex_stall);
            end
        end
        drive_idle(); redir_ready = 1'b1;
        @(negedge clk); redir_ready = 1'b0;
        checks++;
        if (redir_valid !== 1'b0 || ex_stall !== 1'b0 || br_count !== 32'd3 || mispred_count !== 32'd2) begin
            errors++; $display("FAIL bne_release got v=%0b s=%0b br=%0d mp=%0d required v=0 s=0 br=3 mp=2",
                               redir_valid, ex_stall, br_count, mispred_count);
        end
        $display("txn bne: fall-through wraps to 0, stalled 5 cycles");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_idle(); ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_pred_taken = 1'b0;
        ex_pc = 64'h1800; ex_target = 64'h2003;
        @(negedge clk); drive_idle(); redir_ready = 1'b1;
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h2002 || flush !== 1'b1) begin
            errors++; $display("FAIL jalr_redirect got v=%0b pc=%0h f=%0b required v=1 pc=2002 f=1", redir_valid, redir_pc, flush);
        end
        @(negedge clk); redir_ready = 1'b0;
        checks++;
        if (redir_valid !== 1'b0 || flush !== 1'b1 || ex_stall !== 1'b1) begin
            errors++; $display("FAIL jalr_early_ack got v=%0b f=%0b s=%0b required v=0 f=1 s=1", redir_valid, flush, ex_stall);
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || ex_stall !== 1'b0) begin
            errors++; $display("FAIL jalr_idle got f=%0b s=%0b required f=0 s=0", flush, ex_stall);
        end
        drive_branch(3'b000, 1'b0, 1'b1, 1'b0, 64'h2002, 64'h3000);
        @(negedge clk); drive_idle();
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h3000 || br_count !== 32'd5 || mispred_count !== 32'd4) begin
            errors++; $display("FAIL b2b_second got v=%0b pc=%0h br=%0d mp=%0d required v=1 pc=3000 br=5 mp=4",
                               redir_valid, redir_pc, br_count, mispred_count);
        end
        redir_ready = 1'b1;
        repeat (4) @(negedge clk);
        redir_ready = 1'b0;
        checks++;
        if (ex_stall !== 1'b0 || redir_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got s=%0b v=%0b required s=0 v=0", ex_stall, redir_valid);
        end
        $display("txn jalr: bit0 cleared, early ack, back-to-back beq redirect");
    endtask

    task automatic test_illegal();
        @(negedge clk);
        drive_branch(3'b010, 1'b1, 1'b0, 1'b0, 64'h5000, 64'h6000);
        @(negedge clk);
        drive_branch(3'b011, 1'b0, 1'b1, 1'b1, 64'h5004, 64'h6000);
        @(negedge clk); drive_idle();
        checks++;
        if (br_count !== 32'd5 || mispred_count !== 32'd4 || redir_valid !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL illegal_f3 got br=%0d mp=%0d v=%0b f=%0b required br=5 mp=4 v=0 f=0",
                               br_count, mispred_count, redir_valid, flush);
        end
        $display("txn illegal: funct3 010/011 ignored");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.br_count_reg = 32'hFFFF_FFFF;
        force dut.mispred_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.br_count_reg;
        release dut.mispred_count_reg;
        drive_idle(); ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pred_taken = 1'b0;
        ex_pc = 64'h7000; ex_target = 64'h8000;
        @(negedge clk); drive_idle();
        checks++;
        if (br_count !== 32'hFFFF_FFFF || mispred_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL saturate got br=%0h mp=%0h required both ffffffff", br_count, mispred_count);
        end
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h8000) begin
            errors++; $display("FAIL sat_redirect got v=%0b pc=%0h required v=1 pc=8000", redir_valid, redir_pc);
        end
        redir_ready = 1'b1;
        repeat (4) @(negedge clk);
        redir_ready = 1'b0;
        $display("txn saturation: counters hold at max");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_branch(3'b100, 1'b1, 1'b0, 1'b0, 64'h9000, 64'hA000);
        @(negedge clk); drive_idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || ex_stall !== 1'b1 || redir_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_wait got f=%0b s=%0b v=%0b required f=0 s=1 v=1", flush, ex_stall, redir_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({redir_valid, flush, ex_stall} !== 3'b000 || br_count !== '0 || mispred_count !== '0) begin
            errors++; $display("FAIL async_reset got v=%0b f=%0b s=%0b br=%0d mp=%0d required all zero",
                               redir_valid, flush, ex_stall, br_count, mispred_count);
        end
        @(negedge clk); rst_n = 1'b1;
        drive_branch(3'b000, 1'b1, 1'b1, 1'b0, 64'hB000, 64'hC000);
        @(negedge clk); drive_idle();
        checks++;
        if (br_count !== 32'd1 || mispred_count !== 32'd0 || redir_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_accept got br=%0d mp=%0d v=%0b required br=1 mp=0 v=0",
                               br_count, mispred_count, redir_valid);
        end
        $display("txn reset: async reset mid-wait, branch accepted after release");
    endtask

    initial begin
        test_reset();
        test_bltu_mispredict();
        test_bge_correct();
        test_bne_wrap_stall();
        test_back_to_back();
        test_illegal();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
